// File: rtl/check_node_unit.sv
// Serial min-sum check node: accumulates DEG variable messages, then emits DEG check messages.
// Latency: first output valid one cycle after the last input accept; one output per cycle after that.
// Backpressure: in_ready drops during EMIT; out_ready=0 holds the current output stable.
module check_node_unit #(
  parameter int DEG = 6,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] msg_from_var,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] msg_to_var,
  output logic [3:0]   out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         cnu_over
);

  typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_e;

  // Index width into the per-edge sign vector
  localparam int           IW      = (DEG > 2) ? $clog2(DEG) : 1;
  localparam logic [3:0]   LAST    = 4'(DEG - 1);
  localparam logic [W-2:0] MAG_MAX = '1;
  localparam logic [W-2:0] ONE_M   = (W-1)'(1);
  localparam logic [W-1:0] ONE_W   = W'(1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [W-2:0]     min1_q, min1_d;
  logic [W-2:0]     min2_q, min2_d;
  logic [3:0]       min1_idx_q, min1_idx_d;
  logic             parity_q, parity_d;
  logic [DEG-1:0]   sign_q, sign_d;

  logic             accept;
  logic             consume;
  logic             in_sign;
  logic [W-2:0]     in_mag;
  logic [W-2:0]     out_mag;
  logic             out_sgn;
  logic [W-1:0]     out_msg;

  assign accept  = (state_q == ACCUM) && in_valid;
  assign consume = (state_q == EMIT) && out_ready;
  assign in_sign = msg_from_var[W-1];

  // Saturating absolute value: the most negative code maps to the largest positive magnitude
  always_comb begin
    in_mag = msg_from_var[W-2:0];
    if (in_sign) begin
      if (msg_from_var[W-2:0] == '0) begin
        in_mag = MAG_MAX;
      end else begin
        in_mag = ~msg_from_var[W-2:0] + ONE_M;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: ACCUM collects DEG inputs, EMIT drains DEG outputs; one counter serves both
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (cnt_q == LAST) begin
        state_d = EMIT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (consume) begin
      if (cnt_q == LAST) begin
        state_d = ACCUM;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Min-sum accumulation registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1_q     <= '0;
      min2_q     <= '0;
      min1_idx_q <= '0;
      parity_q   <= 1'b0;
      sign_q     <= '0;
    end else begin
      min1_q     <= min1_d;
      min2_q     <= min2_d;
      min1_idx_q <= min1_idx_d;
      parity_q   <= parity_d;
      sign_q     <= sign_d;
    end
  end

  // Track the two smallest magnitudes (strict compare keeps the earliest min1 on ties) and sign parity
  always_comb begin
    min1_d     = min1_q;
    min2_d     = min2_q;
    min1_idx_d = min1_idx_q;
    parity_d   = parity_q;
    sign_d     = sign_q;
    if (accept) begin
      sign_d[cnt_q[IW-1:0]] = in_sign;
      if (cnt_q == 4'd0) begin
        min1_d     = in_mag;
        min2_d     = MAG_MAX;
        min1_idx_d = 4'd0;
        parity_d   = in_sign;
      end else begin
        parity_d = parity_q ^ in_sign;
        if (in_mag < min1_q) begin
          min2_d     = min1_q;
          min1_d     = in_mag;
          min1_idx_d = cnt_q;
        end else if (in_mag < min2_q) begin
          min2_d = in_mag;
        end
      end
    end
  end

  // Output message: exclude the edge's own contribution from both magnitude and sign
  always_comb begin
    out_mag = (cnt_q == min1_idx_q) ? min2_q : min1_q;
    out_sgn = parity_q ^ sign_q[cnt_q[IW-1:0]];
    out_msg = {1'b0, out_mag};
    if (out_sgn) begin
      out_msg = ~out_msg + ONE_W;
    end
  end

  // Output decode from registered state; cnu_over marks the final consume of a block
  always_comb begin
    in_ready   = (state_q == ACCUM);
    out_valid  = (state_q == EMIT);
    out_idx    = (state_q == EMIT) ? cnt_q : 4'd0;
    msg_to_var = (state_q == EMIT) ? out_msg : '0;
    cnu_over   = consume && (cnt_q == LAST);
  end

endmodule
